// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch front end with a small {PC, INST} queue toward decode
// Redirects flush everything; a zero word from the ROM parks fetch until the next redirect.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] ADDR,
  input  logic [31:0] INST,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_PC,
  output logic [31:0] OUT_INST,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        HALTED
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic          r_halted;
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];

  logic          w_full;
  logic          w_deq;
  logic          w_enq_ok;
  logic          w_zero_word;
  logic          w_write;
  logic [31:0]   w_redirect_pc;

  assign w_full        = (r_count == CW'(DEPTH));
  assign OUT_VALID     = (r_count != '0);
  assign w_deq         = OUT_VALID & OUT_READY & ~REDIRECT;
  // A full queue still accepts a new word when the head leaves in the same cycle.
  assign w_enq_ok      = (r_state == S_RUN) & ~REDIRECT & (~w_full | w_deq);
  assign w_zero_word   = (INST == 32'h0);
  assign w_write       = w_enq_ok & ~w_zero_word;
  assign w_redirect_pc = REDIRECT_PC & ~32'h3;

  assign ADDR     = r_fetch_pc;
  assign OUT_PC   = OUT_VALID ? r_pc_mem[r_rd_ptr]   : 32'h0;
  assign OUT_INST = OUT_VALID ? r_inst_mem[r_rd_ptr] : 32'h0;
  assign HALTED   = r_halted;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_RUN;
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_halted   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= 32'h0;
        r_inst_mem[i] <= 32'h0;
      end
    end else if (REDIRECT) begin
      r_state    <= S_RUN;
      r_fetch_pc <= w_redirect_pc;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_halted   <= 1'b0;
    end else begin
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_write) begin
        r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
        r_inst_mem[r_wr_ptr] <= INST;
        r_wr_ptr             <= r_wr_ptr + PW'(1);
        r_fetch_pc           <= r_fetch_pc + 32'd4;
      end
      // Backpressure simply holds fetch_pc; the ROM is re-read next cycle.
      if (w_enq_ok && w_zero_word) begin
        r_state  <= S_HALT;
        r_halted <= 1'b1;
      end
      r_count <= r_count + CW'(w_write) - CW'(w_deq);
    end
  end

endmodule
